// File: rtl/spi_frame_loader_if.sv
// spi_frame_loader_if
//   Bundles the SPI slave pins and the channel-memory write port of
//   spi_frame_loader.
//   master : host/top-level side; drives the SPI pins, observes the write port
//   slave  : loader side; samples the SPI pins, drives the write port
//   Signals: spi_sck, spi_cs_n, spi_mosi (async SPI mode 0, MSB first),
//            mem_we, mem_waddr, mem_wdata (one-clk write strobe + address/data),
//            frame_done, overrun (one-clk status pulses)
interface spi_frame_loader_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  spi_sck;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [7:0]            mem_wdata;
    logic                  frame_done;
    logic                  overrun;

    modport master (
        output spi_sck, spi_cs_n, spi_mosi,
        input  mem_we, mem_waddr, mem_wdata, frame_done, overrun
    );

    modport slave (
        input  spi_sck, spi_cs_n, spi_mosi,
        output mem_we, mem_waddr, mem_wdata, frame_done, overrun
    );
endinterface

// File: rtl/spi_frame_loader.sv
// spi_frame_loader
//   SPI mode-0 slave that writes LED channel bytes into the strip driver's
//   frame memory. A transaction is two address header bytes (high, low)
//   followed by data bytes written at auto-incrementing addresses.
//   Ports:
//     clk     system clock
//     rst     synchronous, active-high reset
//     bus_if  SPI pins in, memory write port and status pulses out
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_IDLE    | cs inactive, waiting for a cs falling edge
//   S_ADDR_HI | receiving header byte 0 (address[15:8])
//   S_ADDR_LO | receiving header byte 1 (address[7:0])
//   S_DATA    | receiving data bytes, writing while address < MAX_CHANNELS
//   S_DRAIN   | cs was already low out of reset; ignore sck until cs rises
module spi_frame_loader #(
    parameter int ADDR_WIDTH   = 13,
    parameter int MAX_CHANNELS = 9
) (
    input logic               clk,
    input logic               rst,
    spi_frame_loader_if.slave bus_if
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    // Synchronisers are deliberately not reset so the cs level is already
    // known when rst releases; that is what lets a mid-frame reset drain.
    logic sck_meta_q, sck_s_q, sck_d_q;
    logic cs_n_meta_q, cs_n_s_q, cs_n_d_q;
    logic mosi_meta_q, mosi_s_q;

    always_ff @(posedge clk) begin
        sck_meta_q  <= bus_if.spi_sck;
        sck_s_q     <= sck_meta_q;
        sck_d_q     <= sck_s_q;
        cs_n_meta_q <= bus_if.spi_cs_n;
        cs_n_s_q    <= cs_n_meta_q;
        cs_n_d_q    <= cs_n_s_q;
        mosi_meta_q <= bus_if.spi_mosi;
        mosi_s_q    <= mosi_meta_q;
    end

    logic sck_rise, cs_active, cs_fall, receiving, bit_tick, byte_done;
    logic [7:0] byte_val;

    // Seven bits are held; the eighth comes straight from mosi on the
    // completing edge so the byte is usable in that same cycle.
    logic [6:0]            shift_q;
    logic [2:0]            bit_cnt_q;
    logic [7:0]            addr_hi_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wrote_q;
    logic                  mem_we_q, frame_done_q, overrun_q;
    logic [ADDR_WIDTH-1:0] mem_waddr_q;
    logic [7:0]            mem_wdata_q;

    logic clr_cnt, latch_hi, load_addr, adv_addr, do_write, do_overrun;
    logic wrote_clr, frame_done_d;

    assign sck_rise  = sck_s_q & ~sck_d_q;
    assign cs_active = ~cs_n_s_q;
    assign cs_fall   = ~cs_n_s_q & cs_n_d_q;
    assign receiving = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) ||
                       (state_q == S_DATA);
    // Requiring cs_active here is what makes a simultaneous cs rise win
    // over a byte-completing sck edge.
    assign bit_tick  = sck_rise & cs_active & receiving;
    assign byte_done = bit_tick & (bit_cnt_q == 3'd7);
    assign byte_val  = {shift_q, mosi_s_q};

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt      = 1'b0;
        latch_hi     = 1'b0;
        load_addr    = 1'b0;
        adv_addr     = 1'b0;
        do_write     = 1'b0;
        do_overrun   = 1'b0;
        wrote_clr    = 1'b0;
        frame_done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                clr_cnt = 1'b1;
                if (cs_fall) begin
                    state_d   = S_ADDR_HI;
                    wrote_clr = 1'b1;
                end else if (cs_active) begin
                    // cs low without a seen falling edge: we came out of
                    // reset mid-transaction, so stay out of the byte stream.
                    state_d = S_DRAIN;
                end
            end
            S_ADDR_HI: begin
                if (!cs_active) state_d = S_IDLE;
                else if (byte_done) begin
                    latch_hi = 1'b1;
                    state_d  = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (!cs_active) state_d = S_IDLE;
                else if (byte_done) begin
                    load_addr = 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (!cs_active) begin
                    state_d      = S_IDLE;
                    frame_done_d = wrote_q;
                end else if (byte_done) begin
                    adv_addr = 1'b1;
                    if (addr_q < ADDR_WIDTH'(MAX_CHANNELS)) do_write   = 1'b1;
                    else                                    do_overrun = 1'b1;
                end
            end
            S_DRAIN: begin
                clr_cnt = 1'b1;
                if (!cs_active) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            addr_hi_q    <= '0;
            addr_q       <= '0;
            wrote_q      <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            mem_we_q     <= do_write;
            frame_done_q <= frame_done_d;
            overrun_q    <= do_overrun;

            if (clr_cnt) begin
                shift_q   <= '0;
                bit_cnt_q <= '0;
            end else if (bit_tick) begin
                shift_q   <= byte_val[6:0];
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            if (latch_hi) addr_hi_q <= byte_val;

            if (load_addr)
                addr_q <= ADDR_WIDTH'({addr_hi_q, byte_val});
            else if (adv_addr && (addr_q != '1))
                addr_q <= addr_q + 1'b1;

            if (do_write) begin
                mem_waddr_q <= addr_q;
                mem_wdata_q <= byte_val;
            end

            if (wrote_clr)     wrote_q <= 1'b0;
            else if (do_write) wrote_q <= 1'b1;
        end
    end

    assign bus_if.mem_we     = mem_we_q;
    assign bus_if.mem_waddr  = mem_waddr_q;
    assign bus_if.mem_wdata  = mem_wdata_q;
    assign bus_if.frame_done = frame_done_q;
    assign bus_if.overrun    = overrun_q;
endmodule

// File: doc/spi_frame_loader.md
Name: spi_frame_loader

Overview:
SPI-mode-0 slave that receives LED channel bytes from an external host and writes them into the frame memory that the strip driver reads. It sits directly upstream of the strip driver: it owns the write port of the channel memory (one byte per channel, address = LED*3 + colour). It signals a completed frame to the top level with a single-cycle pulse.

Parameters:
ADDR_WIDTH, 13, width of the memory write address; matches the strip driver read address.
MAX_CHANNELS, 9, number of valid channel bytes (NUM_LEDS*3); writes at or beyond this address are dropped.

Ports:
clk  input  1  system clock (16 MHz on board)
rst  input  1  synchronous, active-high reset
spi_sck  input  1  SPI clock, asynchronous to clk; max clk/4
spi_cs_n  input  1  SPI chip select, active low, asynchronous
spi_mosi  input  1  SPI data in, MSB first, asynchronous
mem_we  output  1  write strobe, one clk wide
mem_waddr  output  ADDR_WIDTH  write address
mem_wdata  output  8  write data
frame_done  output  1  one-clk pulse: transaction wrote at least one byte and has ended
overrun  output  1  one-clk pulse: a data byte was dropped for address >= MAX_CHANNELS

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Synchronisation: spi_sck, spi_cs_n and spi_mosi each pass through 2 flops. A third flop on sck gives rise detect: sck_s=1 and sck_d=0. cs is active when the synced cs_n is 0.
- Bit capture: on each synced sck rise while cs is active, shift synced mosi into an 8-bit shift register, MSB first. A 3-bit counter wraps 7->0 to mark a complete byte.
- Transaction framing: 2 header bytes, then N data bytes.
  - Header byte 0 is address[15:8]; header byte 1 is address[7:0].
  - Start address = the 16-bit value truncated to ADDR_WIDTH bits.
  - The write address auto-increments after each data byte.
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA, DRAIN.
  - IDLE -> ADDR_HI on synced cs falling (cs_n 1->0). The bit counter clears.
  - ADDR_HI -> ADDR_LO on byte complete; latch high byte.
  - ADDR_LO -> DATA on byte complete; load the address register.
  - DATA, byte complete, address < MAX_CHANNELS: write the byte, increment the address.
  - DATA, byte complete, address >= MAX_CHANNELS: no write, pulse overrun, increment the address. The address saturates at all-ones and does not wrap.
  - Any state: synced cs high -> IDLE.
  - Leaving DATA with at least one write performed pulses frame_done for exactly 1 clk, in the cycle after cs rise detection.
  - Partial bytes (bit counter != 0) at cs rise are discarded.
  - A header that is cut short produces no writes and no frame_done.
- Write timing: mem_we is registered. It is high for exactly the one clk following the synced sck rise that completes the byte. mem_waddr and mem_wdata are valid in that same cycle and hold their values otherwise.
  - Latency from spi_sck pin rise to mem_we high is 3-4 clk edges.
- Reset values: mem_we=0, mem_waddr=0, mem_wdata=0, frame_done=0, overrun=0. FSM goes to IDLE; shift register and bit counter are cleared.
- Reset mid-transaction: the FSM enters DRAIN, not IDLE, if synced cs is still active when rst deasserts.
  - DRAIN ignores all sck edges and exits to IDLE only when cs goes high.
  - This prevents a misaligned byte stream.
- Simultaneous events: if cs rise and a byte-complete sck edge are detected in the same cycle, cs rise wins and the byte is discarded.
- The host must not issue back-to-back frames faster than the memory consumer tolerates. There is no backpressure; a write that overlaps a strip driver read of the same address is acceptable (tearing within a frame is allowed).

Test Plan:
1. rst for 4 clks, then CS low; send 0x00,0x00,0x11,0x22,0x33; CS high -> three mem_we pulses (addr0=0x11, addr1=0x22, addr2=0x33), then one frame_done pulse; overrun never asserts.
2. Header 0x00,0x07, then 4 data bytes 0xA0..0xA3 -> writes addr7=0xA0 and addr8=0xA1; two overrun pulses; no mem_we for the 3rd and 4th bytes; frame_done=1 once.
3. CS low, header 0x00,0x02, then 5 bits of data, CS high -> no mem_we, no frame_done. The next full transaction (0x00,0x02,0x5A) writes addr2=0x5A.
4. Assert rst in the middle of the 2nd data byte with CS held low; release; continue clocking 16 bits -> no mem_we until CS high. A following fresh transaction behaves as in test 1.
5. Header only (0x00,0x00), then CS high -> no mem_we, no frame_done. Header 0x1F,0xFF, data 0x01 -> mem_waddr truncated to 0x1FFF >= MAX_CHANNELS, so one overrun pulse and no write.
6. SCK at exactly clk/4 with randomized clk-to-SCK phase, 9 bytes of data at address 0 -> all 9 bytes written in order with correct values; each mem_we is exactly 1 clk wide.
